// File: rtl/fifo_pkg.sv
// Shared definitions for FIFO-side blocks: buffered-word occupancy encoding and
// the default word width.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Words already buffered plus the one still in flight from the FIFO.
  function automatic logic [1:0] occ_pending(input occ_e occ, input logic inflight);
    return 2'(occ) + {1'b0, inflight};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: registered read data one cycle after a qualified read,
// combinational empty/full flags derived from the stored word count.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  w_wr;
  logic                  w_rd;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign count = r_count;
  assign dout  = r_dout;
  assign w_wr  = wr_en && !full;
  assign w_rd  = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
        r_dout <= r_mem[r_rptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops words from a registered-output FIFO and presents them on a valid/ready
// stream, using a two-entry buffer (OUT + SKID) to hide the FIFO read latency.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
);

  occ_e                  r_occ;
  occ_e                  w_occ_nxt;
  logic                  r_inflight;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] w_out_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;
  logic                  w_pop;
  logic                  w_cap;
  logic [1:0]            w_pending;

  assign w_pop     = r_valid && m_ready;
  assign w_cap     = r_inflight;
  assign w_pending = occ_pending(r_occ, r_inflight);

  // Only issue a read if a slot is guaranteed free when the data lands.
  assign fifo_rd_en = !rst && !fifo_empty &&
                      ((w_pending < 2'd2) || ((w_pending == 2'd2) && w_pop));

  always_comb begin
    w_occ_nxt  = r_occ;
    w_out_nxt  = r_out;
    w_skid_nxt = r_skid;
    case (r_occ)
      OCC_EMPTY: begin
        if (w_cap) begin
          w_occ_nxt = OCC_ONE;
          w_out_nxt = fifo_dout;
        end
      end
      OCC_ONE: begin
        if (w_cap && w_pop) begin
          w_out_nxt = fifo_dout;
        end else if (w_cap) begin
          w_occ_nxt  = OCC_TWO;
          w_skid_nxt = fifo_dout;
        end else if (w_pop) begin
          w_occ_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (w_pop) begin
          w_out_nxt = r_skid;
          if (w_cap) w_skid_nxt = fifo_dout;
          else       w_occ_nxt  = OCC_ONE;
        end
      end
      default: w_occ_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ      <= OCC_EMPTY;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_out      <= '0;
      r_skid     <= '0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= fifo_rd_en;
      r_valid    <= (w_occ_nxt != OCC_EMPTY);
      r_out      <= w_out_nxt;
      r_skid     <= w_skid_nxt;
    end
  end

  assign m_valid   = r_valid;
  assign m_data    = r_out;
  assign occupancy = 2'(r_occ);

endmodule
